reg_file_cfg: RTL and testbench

- Parametrised, single-port synchronous register file for the low-power multi-clock system.
- Successor to the fixed 16x16 register file.
- Adds per-byte write strobes, a registered read-valid flag and an error flag.
- Adds per-address write protection, programmable reset defaults and direct configuration outputs REG0..REG3.
- Sits between the system controller (which issues read/write commands) and the ALU, UART and clock divider (which consume REG0..REG3).

---
 rtl/reg_file_cfg.sv | 96 +++++++++
 tb/tb_reg_file_cfg.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_cfg.sv
// Parametrised single-port register file with byte strobes, write protection,
// a registered read-valid pulse, a reject flag and direct views of entries 0..3.
module reg_file_cfg #(
  parameter int                 WIDTH    = 16,
  parameter int                 DEPTH    = 16,
  parameter int                 ADDR_W   = 4,
  parameter logic [DEPTH-1:0]   RO_MASK  = '0,
  parameter logic [WIDTH-1:0]   REG2_RST = WIDTH'(16'h0081),
  parameter logic [WIDTH-1:0]   REG3_RST = WIDTH'(16'h0020)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                WrEn,
  input  logic                RdEn,
  input  logic [ADDR_W-1:0]   Address,
  input  logic [WIDTH-1:0]    WrData,
  input  logic [WIDTH/8-1:0]  WrStrb,
  output logic [WIDTH-1:0]    RdData,
  output logic                RdData_Valid,
  output logic                Err,
  output logic [WIDTH-1:0]    REG0,
  output logic [WIDTH-1:0]    REG1,
  output logic [WIDTH-1:0]    REG2,
  output logic [WIDTH-1:0]    REG3
);

  localparam int NumLanes = WIDTH / 8;

  logic [WIDTH-1:0] regs [DEPTH];

  logic             addrHit [DEPTH];
  logic             inRange;
  logic             roHit;
  logic             wrOk;
  logic             rdOk;
  logic             reject;
  logic [WIDTH-1:0] rdMux;

  // Address decode, protection lookup and read mux share one one-hot scan so
  // an out-of-range address simply matches nothing.
  // NOTE: every always_comb output gets a default before any branch, otherwise
  // an unassigned path infers a latch.
  always_comb begin
    inRange = 1'b0;
    roHit   = 1'b0;
    rdMux   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      addrHit[i] = (Address == ADDR_W'(i));
      if (addrHit[i]) begin
        inRange = 1'b1;
        roHit   = RO_MASK[i];
        rdMux   = regs[i];
      end
    end
  end

  always_comb begin
    wrOk   = WrEn && !RdEn && inRange && !roHit;
    rdOk   = RdEn && !WrEn && inRange;
    reject = (WrEn || RdEn) && !wrOk && !rdOk;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the storage is reset entry by entry on purpose; the programmable
      // defaults must appear on REG2/REG3 immediately, so this stays as flops.
      for (int i = 0; i < DEPTH; i++) begin
        if (i == 2)      regs[i] <= REG2_RST;
        else if (i == 3) regs[i] <= REG3_RST;
        else             regs[i] <= '0;
      end
      RdData       <= '0;
      RdData_Valid <= 1'b0;
      Err          <= 1'b0;
    end else begin
      RdData_Valid <= rdOk;
      Err          <= reject;
      if (rdOk) RdData <= rdMux;
      for (int i = 0; i < DEPTH; i++) begin
        if (wrOk && addrHit[i]) begin
          for (int k = 0; k < NumLanes; k++) begin
            if (WrStrb[k]) regs[i][8*k +: 8] <= WrData[8*k +: 8];
          end
        end
      end
    end
  end

  assign REG0 = regs[0];
  assign REG1 = regs[1];
  assign REG2 = regs[2];
  assign REG3 = regs[3];

endmodule

// File: tb/tb_reg_file_cfg.sv
// Bench for reg_file_cfg: directed vector table plus randomized traffic checked
// against an array-based model of the register file.
module tb_reg_file_cfg;

  localparam int          WIDTH  = 16;
  localparam int          DEPTH  = 12;
  localparam int          ADDR_W = 4;
  localparam logic [15:0] RO_TB  = 16'h0008;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        WrEn = 1'b0;
  logic        RdEn = 1'b0;
  logic [3:0]  Address = '0;
  logic [15:0] WrData = '0;
  logic [1:0]  WrStrb = '0;
  logic [15:0] RdData;
  logic        RdData_Valid;
  logic        Err;
  logic [15:0] REG0, REG1, REG2, REG3;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  reg_file_cfg #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .RO_MASK (12'h008),
    .REG2_RST(16'h0081),
    .REG3_RST(16'h0020)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .WrEn        (WrEn),
    .RdEn        (RdEn),
    .Address     (Address),
    .WrData      (WrData),
    .WrStrb      (WrStrb),
    .RdData      (RdData),
    .RdData_Valid(RdData_Valid),
    .Err         (Err),
    .REG0        (REG0),
    .REG1        (REG1),
    .REG2        (REG2),
    .REG3        (REG3)
  );

  // Reference model state
  logic [15:0] mRegs [16];
  logic [15:0] mRd;
  logic        mValid;
  logic        mErr;

  typedef struct {
    logic        rst;
    logic        wr;
    logic        rd;
    logic [3:0]  addr;
    logic [15:0] data;
    logic [1:0]  strb;
    logic [15:0] expRd;
    logic        expValid;
    logic        expErr;
    int          regIdx;
    logic [15:0] regVal;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic wr, input logic rd,
                            input logic [3:0] addr, input logic [15:0] data,
                            input logic [1:0] strb);
    logic rej;
    if (rst) begin
      for (int i = 0; i < 16; i++) mRegs[i] = 16'h0000;
      mRegs[2] = 16'h0081;
      mRegs[3] = 16'h0020;
      mRd = 16'h0000; mValid = 1'b0; mErr = 1'b0;
    end else begin
      rej = (wr || rd) && ((wr && rd) || (int'(addr) >= DEPTH) || (wr && RO_TB[addr]));
      mErr = rej;
      mValid = 1'b0;
      if (!rej && wr) begin
        if (strb[0]) mRegs[addr][7:0]  = data[7:0];
        if (strb[1]) mRegs[addr][15:8] = data[15:8];
      end
      if (!rej && rd) begin
        mRd = mRegs[addr];
        mValid = 1'b1;
      end
    end
  endtask

  task automatic cycle(input logic rst, input logic wr, input logic rd,
                       input logic [3:0] addr, input logic [15:0] data,
                       input logic [1:0] strb);
    RST = rst; WrEn = wr; RdEn = rd; Address = addr; WrData = data; WrStrb = strb;
    @(posedge CLK);
    #1;
    model_step(rst, wr, rd, addr, data, strb);
    check("model_RdData", RdData, mRd);
    check("model_Valid", RdData_Valid, mValid);
    check("model_Err", Err, mErr);
    check("model_REG0", REG0, mRegs[0]);
    check("model_REG1", REG1, mRegs[1]);
    check("model_REG2", REG2, mRegs[2]);
    check("model_REG3", REG3, mRegs[3]);
  endtask

  function automatic vec_t mk(logic rst, logic wr, logic rd, logic [3:0] addr,
                              logic [15:0] data, logic [1:0] strb, logic [15:0] expRd,
                              logic expValid, logic expErr, int regIdx, logic [15:0] regVal);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.addr = addr; v.data = data; v.strb = strb;
    v.expRd = expRd; v.expValid = expValid; v.expErr = expErr;
    v.regIdx = regIdx; v.regVal = regVal;
    return v;
  endfunction

  function automatic logic [15:0] reg_view(int idx);
    case (idx)
      0:       return REG0;
      1:       return REG1;
      2:       return REG2;
      default: return REG3;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) mRegs[i] = 16'h0000;
    mRd = '0; mValid = 1'b0; mErr = 1'b0;

    //            rst wr rd addr  data      strb   expRd    V  E  reg  regVal
    vecs.push_back(mk(1, 0, 0, 4'd0,  16'h0000, 2'b00, 16'h0000, 0, 0, 2, 16'h0081));
    vecs.push_back(mk(1, 1, 1, 4'd2,  16'hFFFF, 2'b11, 16'h0000, 0, 0, 3, 16'h0020));
    vecs.push_back(mk(0, 0, 0, 4'd0,  16'h0000, 2'b00, 16'h0000, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 1, 4'd3,  16'h0000, 2'b00, 16'h0020, 1, 0, 1, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 4'd5,  16'hA5C3, 2'b11, 16'h0020, 0, 0, 3, 16'h0020));
    vecs.push_back(mk(0, 1, 0, 4'd5,  16'h1234, 2'b01, 16'h0020, 0, 0, 2, 16'h0081));
    vecs.push_back(mk(0, 0, 1, 4'd5,  16'h0000, 2'b00, 16'hA534, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 4'd1,  16'h0013, 2'b11, 16'hA534, 0, 0, 1, 16'h0013));
    vecs.push_back(mk(0, 0, 1, 4'd1,  16'h0000, 2'b00, 16'h0013, 1, 0, 1, 16'h0013));
    vecs.push_back(mk(0, 1, 1, 4'd2,  16'hFFFF, 2'b11, 16'h0013, 0, 1, 2, 16'h0081));
    vecs.push_back(mk(0, 0, 0, 4'd0,  16'h0000, 2'b00, 16'h0013, 0, 0, 2, 16'h0081));
    vecs.push_back(mk(0, 1, 0, 4'd3,  16'h00FF, 2'b11, 16'h0013, 0, 1, 3, 16'h0020));
    vecs.push_back(mk(0, 0, 1, 4'd14, 16'h0000, 2'b00, 16'h0013, 0, 1, 3, 16'h0020));
    vecs.push_back(mk(0, 1, 0, 4'd13, 16'hBEEF, 2'b11, 16'h0013, 0, 1, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 4'd4,  16'hFFFF, 2'b00, 16'h0013, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 1, 4'd4,  16'h0000, 2'b00, 16'h0000, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 4'd2,  16'h5500, 2'b10, 16'h0000, 0, 0, 2, 16'h5581));
    vecs.push_back(mk(0, 1, 0, 4'd7,  16'h0016, 2'b11, 16'h0000, 0, 0, 2, 16'h5581));
    vecs.push_back(mk(1, 0, 1, 4'd7,  16'h0000, 2'b00, 16'h0000, 0, 0, 2, 16'h0081));
    vecs.push_back(mk(0, 0, 1, 4'd7,  16'h0000, 2'b00, 16'h0000, 1, 0, 0, 16'h0000));

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].strb);
      check($sformatf("vec%0d_RdData", i), RdData, vecs[i].expRd);
      check($sformatf("vec%0d_Valid", i), RdData_Valid, vecs[i].expValid);
      check($sformatf("vec%0d_Err", i), Err, vecs[i].expErr);
      check($sformatf("vec%0d_REG%0d", i, vecs[i].regIdx), reg_view(vecs[i].regIdx), vecs[i].regVal);
    end

    // Back-to-back reads: one valid pulse per cycle, each with its own data.
    cycle(0, 1, 0, 4'd9, 16'h9999, 2'b11);
    cycle(0, 1, 0, 4'd10, 16'hAAAA, 2'b11);
    cycle(0, 0, 1, 4'd9, 16'h0000, 2'b00);
    check("b2b_first", {15'd0, RdData_Valid, RdData}, {15'd0, 1'b1, 16'h9999});
    cycle(0, 0, 1, 4'd10, 16'h0000, 2'b00);
    check("b2b_second", {15'd0, RdData_Valid, RdData}, {15'd0, 1'b1, 16'hAAAA});
    cycle(0, 0, 0, 4'd0, 16'h0000, 2'b00);
    check("b2b_hold", {15'd0, RdData_Valid, RdData}, {15'd0, 1'b0, 16'hAAAA});

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic r;
      logic w;
      logic d;
      r = ($urandom_range(0, 49) == 0);
      w = ($urandom_range(0, 2) != 0);
      d = ($urandom_range(0, 2) != 0);
      cycle(r, w, d, 4'($urandom_range(0, 15)), 16'($urandom), 2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
